req_ack_responder: RTL
======================

// Module: req_ack_responder
// PURPOSE
//  Responder end of the req/ack handshake checked by the block's SVA properties. Every req
//  pulse carries a DATA_W payload. After exactly ACK_DELAY cycles the block returns a one-cycle
//  ack with either a valid/data response or an error flag.
//  The block is pipelined: back-to-back reqs are legal, and each req is acked independently.
//  It sits between the request initiator and downstream consumers, with bounded-latency
//  guarantees so that req |-> ##[1:3] ack always holds.
// PARAMETERS
//  DATA_W     8   payload width
//  ACK_DELAY  1   req-to-ack latency in cycles; legal range 1..3 (elaboration error otherwise)
//  CNT_W      16  width of the saturating statistics counters
// PORTS
//  clk        in   1        rising-edge clock
//  reset_n    in   1        asynchronous active-low reset
//  req        in   1        request strobe; each high cycle is one independent request
//  req_data   in   DATA_W   payload, sampled in the same cycle req=1
//  flush      in   1        synchronous; kills all in-flight requests (no ack issued)
//  ack        out  1        one-cycle response strobe
//  valid      out  1        response carries good data; only ever high together with ack
//  data       out  DATA_W   response payload; equals the req_data captured for this ack
//  error      out  1        request payload was all-zero; only ever high together with ack
//  busy       out  1        one or more requests are in flight
//  req_cnt    out  CNT_W    saturating count of accepted requests
//  err_cnt    out  CNT_W    saturating count of error responses
// BEHAVIOUR
//  - Reset (async assert, sync release): every output is 0 and all pipeline stages are empty.
//    Reset asserted mid-operation drops in-flight requests; no ack follows after release.
//  - Pipeline: ACK_DELAY stages, each holding {vld, payload}. Stage 0 loads {req, req_data}
//    every cycle, and the stages shift each cycle. No stalls and no backpressure.
//  - Output stage: ack = last-stage vld. When ack is high:
//    - Nonzero payload: valid=1, error=0, data=payload.
//    - Zero payload: valid=0, error=1, data=0.
//    When ack is low, valid, error and data are all 0.
//  - Invariants: valid and error are never both 1; valid implies data!=0; every req cycle is
//    followed by ack exactly ACK_DELAY cycles later, unless reset or flush occurs in between.
//  - ACK_DELAY=1: ack is registered from req, so req |=> ack holds.
//  - busy = OR of all stage vld bits, taken after the shift (registered).
//  - flush=1 clears all stage vld bits at the next edge, and any req in the same cycle is also
//    discarded. The ack that is already on the outputs in the flush cycle stays valid;
//    ack is 0 from the next cycle onward.
//  - req_cnt increments on each req cycle that is not flushed, and holds at 2^CNT_W-1.
//    err_cnt increments with each error pulse, and saturates the same way.
//  - Counters are cleared only by reset; flush does not clear them.
// TESTING
//  1. ACK_DELAY=2; req=1 with req_data=8'h5A for one cycle ->
//     2 cycles later: ack=1, valid=1, data=8'h5A, error=0 for exactly one cycle; req_cnt=1.
//  2. ACK_DELAY=3; req held for 4 consecutive cycles with data 01,02,00,04 ->
//     4 consecutive acks: valid,valid,error,valid; data 01,02,00,04; err_cnt=1; busy high for 6 cycles.
//  3. ACK_DELAY=3; req at cycle t, then reset_n low at t+1 for one cycle ->
//     all outputs 0 immediately; no ack at t+3.
//  4. ACK_DELAY=2; reqs at t and t+1, flush at t+1 ->
//     neither request is acked; req_cnt=1, because only the cycle-t req is counted.
//  5. CNT_W=4; 20 reqs with payload 0 ->
//     20 error pulses, valid never 1, err_cnt=req_cnt=15 (saturated).
//  6. Bind the SVA properties with disable iff (!reset_n) over random req/req_data/flush:
//     req |-> ##[1:3] ack passes whenever flush is held 0; valid |-> !error and
//     valid |-> data!=0 always pass.

Source files
------------

// File: rtl/req_ack_responder.sv
// Responder end of a req/ack handshake: every req is answered exactly ACK_DELAY cycles
// later with a one-cycle ack carrying either the captured payload (valid) or an error flag.
module req_ack_responder #(
    parameter int DATA_W    = 8,
    parameter int ACK_DELAY = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [DATA_W-1:0] req_data,
    input  logic              flush,
    output logic              ack,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              error,
    output logic              busy,
    output logic [CNT_W-1:0]  req_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    if (ACK_DELAY < 1 || ACK_DELAY > 3) begin : g_bad_delay
        $error("req_ack_responder: ACK_DELAY must be in 1..3");
    end

    logic [ACK_DELAY-1:0] r_vld;
    logic [DATA_W-1:0]    r_pay [ACK_DELAY];
    logic                 r_valid;
    logic                 r_error;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_req_cnt;
    logic [CNT_W-1:0]     r_err_cnt;

    logic [ACK_DELAY-1:0] w_vld_nxt;
    logic [DATA_W-1:0]    w_raw [ACK_DELAY];
    logic [DATA_W-1:0]    w_pay_nxt [ACK_DELAY];
    logic                 w_req_acc;
    logic                 w_last_nz;
    logic                 w_good_nxt;
    logic                 w_err_nxt;

    // Next pipeline contents; the last stage stores the already-masked response payload
    always_comb begin
        w_vld_nxt  = {ACK_DELAY{1'b0}};
        for (int i = 0; i < ACK_DELAY; i++) begin
            w_raw[i]     = {DATA_W{1'b0}};
            w_pay_nxt[i] = {DATA_W{1'b0}};
        end
        w_req_acc    = req & ~flush;
        w_vld_nxt[0] = w_req_acc;
        w_raw[0]     = req_data;
        for (int i = 1; i < ACK_DELAY; i++) begin
            w_vld_nxt[i] = r_vld[i-1] & ~flush;
            w_raw[i]     = r_pay[i-1];
        end
        w_last_nz  = |w_raw[ACK_DELAY-1];
        w_good_nxt = w_vld_nxt[ACK_DELAY-1] & w_last_nz;
        w_err_nxt  = w_vld_nxt[ACK_DELAY-1] & ~w_last_nz;
        for (int i = 0; i < ACK_DELAY; i++) begin
            w_pay_nxt[i] = w_raw[i];
        end
        if (w_good_nxt) begin
            w_pay_nxt[ACK_DELAY-1] = w_raw[ACK_DELAY-1];
        end else begin
            w_pay_nxt[ACK_DELAY-1] = {DATA_W{1'b0}};
        end
    end

    // Pipeline shift, registered response flags and saturating statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld     <= {ACK_DELAY{1'b0}};
            for (int i = 0; i < ACK_DELAY; i++) begin
                r_pay[i] <= {DATA_W{1'b0}};
            end
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b0;
            r_req_cnt <= {CNT_W{1'b0}};
            r_err_cnt <= {CNT_W{1'b0}};
        end else begin
            r_vld <= w_vld_nxt;
            for (int i = 0; i < ACK_DELAY; i++) begin
                r_pay[i] <= w_pay_nxt[i];
            end
            r_valid <= w_good_nxt;
            r_error <= w_err_nxt;
            r_busy  <= |w_vld_nxt;
            if (w_req_acc && (r_req_cnt != {CNT_W{1'b1}})) begin
                r_req_cnt <= r_req_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_req_cnt <= r_req_cnt;
            end
            // err_cnt steps on the same edge that raises the error pulse
            if (w_err_nxt && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end
    end

    assign ack     = r_vld[ACK_DELAY-1];
    assign data    = r_pay[ACK_DELAY-1];
    assign valid   = r_valid;
    assign error   = r_error;
    assign busy    = r_busy;
    assign req_cnt = r_req_cnt;
    assign err_cnt = r_err_cnt;

endmodule
